down_count_wrap_monitor: RTL and testbench

- Sits directly downstream of the 4-bit synchronous down counter and consumes its count output every clock.
- Detects underflow wraps (0 -> max), keeps a running wrap total, and raises a batched interrupt with an irq/ack handshake.
- Flags sequence errors: any count change that is neither a hold, a single decrement, nor a wrap.

---
 rtl/down_count_wrap_monitor_pkg.sv | 20 ++
 rtl/down_count_wrap_monitor_classifier.sv | 37 +++
 rtl/down_count_wrap_monitor.sv | 143 ++++++++++++++
 tb/tb_down_count_wrap_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_count_wrap_monitor_pkg.sv
// Shared types and constants for the down-counter wrap monitor.
// Holds the IRQ FSM state, the step classification and batch counter sizing.
package down_count_wrap_monitor_pkg;

    typedef enum logic {
        StIdle,
        StIrq
    } irq_state_e;

    typedef enum logic [1:0] {
        ClsHold,
        ClsStep,
        ClsWrap,
        ClsOther
    } step_class_e;

    localparam int unsigned BatchW = 3;
    localparam logic [BatchW-1:0] BatchMax = 3'd7;

endpackage

// File: rtl/down_count_wrap_monitor_classifier.sv
// Combinational classifier: compares a new count sample against the previous one
// and reports hold, single decrement, underflow wrap, or anything else.
module count_step_classifier
    import down_count_wrap_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_prev_count,
    input  logic [WIDTH-1:0] i_count_in,
    input  logic             i_prev_valid,
    output step_class_e      o_class
);

    localparam logic [WIDTH-1:0] CountOne = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CountMax = {WIDTH{1'b1}};

    logic [WIDTH-1:0] w_prev_dec;

    assign w_prev_dec = i_prev_count - CountOne;

    always_comb begin
        o_class = ClsHold;
        // Without a valid previous sample there is nothing to compare against.
        if (i_prev_valid) begin
            if (i_count_in == i_prev_count) begin
                o_class = ClsHold;
            end else if ((i_prev_count == '0) && (i_count_in == CountMax)) begin
                o_class = ClsWrap;
            end else if ((i_prev_count != '0) && (i_count_in == w_prev_dec)) begin
                o_class = ClsStep;
            end else begin
                o_class = ClsOther;
            end
        end
    end

endmodule

// File: rtl/down_count_wrap_monitor.sv
// Watches a down counter for underflow wraps, totals them, batches them into an
// acknowledged interrupt, and flags discontinuous count sequences.
module down_count_wrap_monitor
    import down_count_wrap_monitor_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned EVT_W      = 8,
    parameter int unsigned IRQ_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample_en,
    input  logic             irq_ack,
    output logic             wrap_pulse,
    output logic [EVT_W-1:0] wrap_count,
    output logic             irq,
    output logic             seq_err,
    output logic             lost
);

    localparam logic [BatchW-1:0] ThreshB  = BatchW'(IRQ_THRESH);
    localparam logic [BatchW:0]   ThreshW  = (BatchW + 1)'(IRQ_THRESH);
    localparam logic [BatchW:0]   BatchMaxW = {1'b0, BatchMax};
    localparam logic [EVT_W-1:0]  EvtOne   = {{(EVT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  r_prev_count;
    logic              r_prev_valid;
    logic              r_wrap_pulse;
    logic [EVT_W-1:0]  r_wrap_count;
    logic [BatchW-1:0] r_batch;
    logic              r_seq_err;
    logic              r_lost;
    logic              r_rearm;
    irq_state_e        r_state;

    step_class_e       w_class;
    logic              w_sample_wrap;
    logic              w_sample_other;
    logic              w_ack;
    logic [BatchW:0]   w_batch_sum;
    logic [BatchW-1:0] w_batch_d;
    logic              w_lost_set;
    logic              w_rearm_d;
    irq_state_e        w_state_d;

    count_step_classifier #(
        .WIDTH (WIDTH)
    ) u_classifier (
        .i_prev_count (r_prev_count),
        .i_count_in   (count_in),
        .i_prev_valid (r_prev_valid),
        .o_class      (w_class)
    );

    assign w_sample_wrap  = sample_en && (w_class == ClsWrap);
    assign w_sample_other = sample_en && (w_class == ClsOther);

    // Only an acknowledge seen while irq is actually asserted counts; this ignores
    // it in IDLE and during the one-cycle re-arm gap.
    assign w_ack = irq_ack && (r_state == StIrq) && !r_rearm;

    // Batch never underflows: in StIrq it is always at least IRQ_THRESH.
    always_comb begin
        w_batch_sum = {1'b0, r_batch} + {{BatchW{1'b0}}, w_sample_wrap};
        if (w_ack) begin
            w_batch_sum = w_batch_sum - ThreshW;
        end
        w_lost_set = 1'b0;
        w_batch_d  = w_batch_sum[BatchW-1:0];
        if (w_batch_sum > BatchMaxW) begin
            w_batch_d  = BatchMax;
            w_lost_set = 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_rearm_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_batch_d >= ThreshB) begin
                    w_state_d = StIrq;
                end
            end
            StIrq: begin
                if (w_ack) begin
                    if (w_batch_d < ThreshB) begin
                        w_state_d = StIdle;
                    end else begin
                        w_rearm_d = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_count <= '0;
            r_prev_valid <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= '0;
            r_seq_err    <= 1'b0;
        end else begin
            r_wrap_pulse <= w_sample_wrap;
            if (sample_en) begin
                r_prev_count <= count_in;
                r_prev_valid <= 1'b1;
            end
            if (w_sample_wrap) begin
                r_wrap_count <= r_wrap_count + EvtOne;
            end
            if (w_sample_other) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_batch <= '0;
            r_lost  <= 1'b0;
            r_rearm <= 1'b0;
            r_state <= StIdle;
        end else begin
            r_batch <= w_batch_d;
            r_rearm <= w_rearm_d;
            r_state <= w_state_d;
            if (w_lost_set) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign wrap_pulse = r_wrap_pulse;
    assign wrap_count = r_wrap_count;
    assign irq        = (r_state == StIrq) && !r_rearm;
    assign seq_err    = r_seq_err;
    assign lost       = r_lost;

endmodule

// File: tb/tb_down_count_wrap_monitor.sv
// Directed bench for down_count_wrap_monitor: wrap detection, batching, irq
// handshake, saturation, sequence errors and asynchronous reset.
module tb_down_count_wrap_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] count_in;
    logic       sample_en;
    logic       irq_ack;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       irq;
    logic       seq_err;
    logic       lost;

    int n_checks;
    int n_errors;

    down_count_wrap_monitor #(
        .WIDTH      (4),
        .EVT_W      (8),
        .IRQ_THRESH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .sample_en  (sample_en),
        .irq_ack    (irq_ack),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .irq        (irq),
        .seq_err    (seq_err),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, let it be clocked, then settle 1 time unit past the edge.
    task automatic tick(input logic [3:0] c, input logic en, input logic ack);
        count_in  = c;
        sample_en = en;
        irq_ack   = ack;
        @(posedge clk);
        #1;
        irq_ack   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        count_in = 4'd0;
        sample_en = 1'b0;
        irq_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({wrap_pulse, wrap_count, irq, seq_err, lost} !== 12'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {wrap_pulse, wrap_count, irq, seq_err, lost});
        end
        reset = 1'b0;
        tick(4'd9, 1'b0, 1'b0);
        tick(4'd3, 1'b0, 1'b1);
        n_checks++;
        if ({wrap_pulse, wrap_count, irq, seq_err, lost} !== 12'd0) begin
            n_errors++;
            $display("FAIL no_change_before_sample: got %h expected 000",
                     {wrap_pulse, wrap_count, irq, seq_err, lost});
        end
    endtask

    task automatic test_wrap();
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b0 || seq_err !== 1'b0) begin
            n_errors++;
            $display("FAIL first_sample: got pulse=%b err=%b expected 0 0", wrap_pulse, seq_err);
        end
        for (int v = 14; v >= 0; v--) begin
            tick(4'(v), 1'b1, 1'b0);
            n_checks++;
            if (wrap_pulse !== 1'b0) begin
                n_errors++;
                $display("FAIL no_pulse_on_step(%0d): got %b expected 0", v, wrap_pulse);
            end
        end
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_pulse_first: got %b expected 1", wrap_pulse);
        end
        n_checks++;
        if (wrap_count !== 8'd1) begin
            n_errors++;
            $display("FAIL wrap_count_first: got %0d expected 1", wrap_count);
        end
        n_checks++;
        if (irq !== 1'b0 || seq_err !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_err_first_wrap: got irq=%b err=%b expected 0 0", irq, seq_err);
        end
        tick(4'd14, 1'b1, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b0 || wrap_count !== 8'd1) begin
            n_errors++;
            $display("FAIL pulse_one_cycle: got pulse=%b count=%0d expected 0 1",
                     wrap_pulse, wrap_count);
        end
    endtask

    task automatic test_irq_assert();
        for (int v = 13; v >= 0; v--) tick(4'(v), 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_before_2nd_wrap: got %b expected 0", irq);
        end
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b1 || wrap_count !== 8'd2) begin
            n_errors++;
            $display("FAIL second_wrap: got pulse=%b count=%0d expected 1 2",
                     wrap_pulse, wrap_count);
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_with_pulse: got %b expected 1", irq);
        end
        tick(4'd14, 1'b1, 1'b1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_after_ack: got %b expected 0", irq);
        end
        tick(4'd13, 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_stays_idle: got %b expected 0", irq);
        end
    endtask

    task automatic test_simul_wrap_ack();
        // batch is 0 here, so one wrap must not raise irq.
        for (int v = 12; v >= 0; v--) tick(4'(v), 1'b1, 1'b0);
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (wrap_count !== 8'd3 || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL batch_cleared_by_ack: got count=%0d irq=%b expected 3 0",
                     wrap_count, irq);
        end
        for (int v = 14; v >= 0; v--) tick(4'(v), 1'b1, 1'b0);
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (wrap_count !== 8'd4 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL batch2_irq: got count=%0d irq=%b expected 4 1", wrap_count, irq);
        end
        for (int v = 14; v >= 0; v--) tick(4'(v), 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_held_unacked: got %b expected 1", irq);
        end
        tick(4'd15, 1'b1, 1'b1);
        n_checks++;
        if (wrap_pulse !== 1'b1 || wrap_count !== 8'd5) begin
            n_errors++;
            $display("FAIL wrap_with_ack: got pulse=%b count=%0d expected 1 5",
                     wrap_pulse, wrap_count);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_wrap_ack: got %b expected 0", irq);
        end
        tick(4'd14, 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_not_rearm: got %b expected 0", irq);
        end
    endtask

    task automatic test_saturation();
        // batch is 1; six wraps bring it to 7 without loss.
        for (int w = 0; w < 6; w++) begin
            for (int v = (w == 0) ? 13 : 14; v >= 0; v--) tick(4'(v), 1'b1, 1'b0);
            tick(4'd15, 1'b1, 1'b0);
            n_checks++;
            if (wrap_count !== 8'(6 + w) || irq !== 1'b1 || lost !== 1'b0) begin
                n_errors++;
                $display("FAIL sat_wrap%0d: got count=%0d irq=%b lost=%b expected %0d 1 0",
                         w, wrap_count, irq, lost, 6 + w);
            end
        end
        for (int v = 14; v >= 0; v--) tick(4'(v), 1'b1, 1'b0);
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (lost !== 1'b1 || wrap_count !== 8'd12) begin
            n_errors++;
            $display("FAIL lost_on_sat: got lost=%b count=%0d expected 1 12", lost, wrap_count);
        end
        // 7 -> 5 -> 3 each re-arm; 3 -> 1 returns to idle.
        tick(4'd15, 1'b1, 1'b1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL rearm1_low: got %b expected 0", irq);
        end
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_errors++;
            $display("FAIL rearm1_high: got %b expected 1", irq);
        end
        tick(4'd15, 1'b1, 1'b1);
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_errors++;
            $display("FAIL rearm2_high: got %b expected 1", irq);
        end
        tick(4'd15, 1'b1, 1'b1);
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (irq !== 1'b0 || lost !== 1'b1) begin
            n_errors++;
            $display("FAIL batch1_idle: got irq=%b lost=%b expected 0 1", irq, lost);
        end
    endtask

    task automatic test_seq_err();
        for (int v = 14; v >= 5; v--) tick(4'(v), 1'b1, 1'b0);
        tick(4'd5, 1'b1, 1'b0);
        n_checks++;
        if (seq_err !== 1'b0 || wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_no_event: got err=%b pulse=%b expected 0 0", seq_err, wrap_pulse);
        end
        tick(4'd9, 1'b1, 1'b0);
        n_checks++;
        if (seq_err !== 1'b1 || wrap_pulse !== 1'b0 || wrap_count !== 8'd12) begin
            n_errors++;
            $display("FAIL jump_seq_err: got err=%b pulse=%b count=%0d expected 1 0 12",
                     seq_err, wrap_pulse, wrap_count);
        end
        tick(4'd3, 1'b1, 1'b0);
        tick(4'd0, 1'b1, 1'b0);
        n_checks++;
        if (seq_err !== 1'b1) begin
            n_errors++;
            $display("FAIL seq_err_sticky: got %b expected 1", seq_err);
        end
        tick(4'd15, 1'b0, 1'b0);
        tick(4'd7, 1'b0, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b0 || wrap_count !== 8'd12) begin
            n_errors++;
            $display("FAIL sample_en_low: got pulse=%b count=%0d expected 0 12",
                     wrap_pulse, wrap_count);
        end
        tick(4'd0, 1'b1, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL prev_held: got %b expected 0", wrap_pulse);
        end
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b1 || wrap_count !== 8'd13 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_after_err: got pulse=%b count=%0d irq=%b expected 1 13 1",
                     wrap_pulse, wrap_count, irq);
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({wrap_pulse, wrap_count, irq, seq_err, lost} !== 12'd0) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected 000",
                     {wrap_pulse, wrap_count, irq, seq_err, lost});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(4'd0, 1'b1, 1'b0);
        n_checks++;
        if (seq_err !== 1'b0 || wrap_pulse !== 1'b0 || wrap_count !== 8'd0) begin
            n_errors++;
            $display("FAIL first_after_reset: got err=%b pulse=%b count=%0d expected 0 0 0",
                     seq_err, wrap_pulse, wrap_count);
        end
        tick(4'd15, 1'b1, 1'b0);
        n_checks++;
        if (wrap_pulse !== 1'b1 || wrap_count !== 8'd1 || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_after_reset: got pulse=%b count=%0d irq=%b expected 1 1 0",
                     wrap_pulse, wrap_count, irq);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_wrap();
        test_irq_assert();
        test_simul_wrap_ack();
        test_saturation();
        test_seq_err();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
